// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and width helper for conv_mac_engine
// Purpose: mode and FSM state enums plus the accumulator width function
//          used by conv_mac_engine and mac_lane.
// Ports:   none (package).
package conv_pkg;

  typedef enum logic {
    MODE_CONV  = 1'b0,
    MODE_DENSE = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  // Full product width plus enough headroom to sum wdepth products.
  function automatic int acc_w(input int data_w, input int wdepth);
    return 2 * data_w + $clog2(wdepth);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one output channel: weight bank, product register, accumulator
// Purpose: stores WDEPTH signed weights for one channel, multiplies the
//          incoming sample by the weight at the current tap, and accumulates
//          the registered product one cycle later.
// Ports:   clk, rst_n      - clock, async active-low reset
//          wr_en/wr_addr/wr_data - weight write (already gated by the top)
//          clr             - clear accumulator and product-valid at window start
//          mul_en          - sample handshake; capture in_data * w[tap]
//          tap, in_data    - tap index and signed sample
//          acc             - signed accumulated result
module mac_lane
  import conv_pkg::*;
#(
  parameter int DATA_W = 23,
  parameter int WDEPTH = 16,
  parameter int ACC_W  = acc_w(DATA_W, WDEPTH),
  parameter int AW     = $clog2(WDEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  input  logic              mul_en,
  input  logic [AW-1:0]     tap,
  input  logic [DATA_W-1:0] in_data,
  output logic [ACC_W-1:0]  acc
);

  localparam int PW = 2 * DATA_W;

  logic [DATA_W-1:0]    w_q [WDEPTH];
  logic [DATA_W-1:0]    w_d [WDEPTH];
  logic signed [PW-1:0] prod_q, prod_d;
  logic                 pv_q, pv_d;
  logic [ACC_W-1:0]     acc_q, acc_d;

  always_comb begin
    w_d = w_q;
    if (wr_en) begin
      w_d[wr_addr] = wr_data;
    end
  end

  // The product is registered on the handshake and folded into the
  // accumulator on the following cycle; pv_q marks a pending product so
  // input gaps add nothing and DRAIN picks up the last one.
  always_comb begin
    prod_d = prod_q;
    pv_d   = mul_en;
    acc_d  = acc_q;
    if (mul_en) begin
      prod_d = $signed(in_data) * $signed(w_q[tap]);
    end
    if (clr) begin
      acc_d = '0;
      pv_d  = 1'b0;
    end else if (pv_q) begin
      acc_d = acc_q + {{(ACC_W - PW){prod_q[PW-1]}}, prod_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WDEPTH; i++) begin
        w_q[i] <= '0;
      end
      prod_q <= '0;
      pv_q   <= 1'b0;
      acc_q  <= '0;
    end else begin
      w_q    <= w_d;
      prod_q <= prod_d;
      pv_q   <= pv_d;
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv_mac_engine.sv
// rtl/conv_mac_engine.sv - multi-channel sequential conv/dense MAC engine
// Purpose: window FSM, tap counter, dense length check and stream
//          handshakes around CH mac_lane instances.
// Ports:   clk, rst_n                      - clock, async active-low reset
//          cfg_we/cfg_ch/cfg_addr/cfg_wdata - weight programming (IDLE only)
//          mode, len, start                - window command
//          in_valid/in_ready/in_data       - sample stream
//          out_valid/out_ready/out_data    - per-channel results
//          busy, err                       - status, rejected-command pulse
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = 23,
  parameter int KSIZE  = 3,
  parameter int CH     = 2,
  parameter int WDEPTH = 16,
  parameter int ACC_W  = acc_w(DATA_W, WDEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(CH)-1:0]      cfg_ch,
  input  logic [$clog2(WDEPTH)-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]          cfg_wdata,
  input  logic                       mode,
  input  logic [$clog2(WDEPTH):0]    len,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH*ACC_W-1:0]        out_data,
  output logic                       busy,
  output logic                       err
);

  localparam int AW = $clog2(WDEPTH);
  localparam int NK = KSIZE * KSIZE;
  localparam logic [AW:0] NK_L     = (AW + 1)'(NK);
  localparam logic [AW:0] WDEPTH_L = (AW + 1)'(WDEPTH);

  generate
    if (NK > WDEPTH) begin : g_bad_cfg
      $error("conv_mac_engine: KSIZE*KSIZE exceeds WDEPTH");
    end
  endgenerate

  state_e      state_q, state_d;
  logic [AW:0] n_q, n_d;
  logic [AW:0] tap_q, tap_d;
  logic        err_q, err_d;
  logic        hs;
  logic        idle;
  logic        clr;
  logic        len_bad;

  assign idle     = (state_q == S_IDLE);
  assign in_ready = (state_q == S_RUN);
  assign out_valid = (state_q == S_OUT);
  assign busy     = !idle;
  assign err      = err_q;
  assign hs       = in_valid && in_ready;
  assign len_bad  = (mode_e'(mode) == MODE_DENSE) && ((len == '0) || (len > WDEPTH_L));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    tap_d   = tap_q;
    err_d   = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_bad) begin
            err_d = 1'b1;
          end else begin
            n_d     = (mode_e'(mode) == MODE_DENSE) ? len : NK_L;
            tap_d   = '0;
            clr     = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (hs) begin
          tap_d = tap_q + 1'b1;
          if (tap_q == n_q - 1'b1) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Weight writes are only legal while idle; anything else is rejected.
    if (cfg_we && !idle) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      tap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      tap_q   <= tap_d;
      err_q   <= err_d;
    end
  end

  generate
    for (genvar c = 0; c < CH; c++) begin : g_lane
      logic [ACC_W-1:0] acc_c;
      mac_lane #(
        .DATA_W (DATA_W),
        .WDEPTH (WDEPTH),
        .ACC_W  (ACC_W),
        .AW     (AW)
      ) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cfg_we && idle && (cfg_ch == c)),
        .wr_addr (cfg_addr),
        .wr_data (cfg_wdata),
        .clr     (clr),
        .mul_en  (hs),
        .tap     (tap_q[AW-1:0]),
        .in_data (in_data),
        .acc     (acc_c)
      );
      assign out_data[c*ACC_W +: ACC_W] = acc_c;
    end
  endgenerate

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb/tb_conv_mac_engine.sv - directed self-checking bench for conv_mac_engine
module tb_conv_mac_engine;

  localparam int DATA_W = 23;
  localparam int ACC_W  = 50;
  localparam int CH     = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     cfg_we = 1'b0;
  logic [0:0]               cfg_ch = '0;
  logic [3:0]               cfg_addr = '0;
  logic [DATA_W-1:0]        cfg_wdata = '0;
  logic                     mode = 1'b0;
  logic [4:0]               len = '0;
  logic                     start = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [CH*ACC_W-1:0]      out_data;
  logic                     busy;
  logic                     err;

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [DATA_W-1:0] samp [16];

  conv_mac_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .mode      (mode),
    .len       (len),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [127:0] got,
                       input logic signed [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [ACC_W-1:0] res(input int c);
    logic [CH*ACC_W-1:0] v;
    v = out_data;
    return v[c*ACC_W +: ACC_W];
  endfunction

  task automatic write_w(input int c, input int a, input logic signed [DATA_W-1:0] d);
    cfg_we = 1'b1; cfg_ch = 1'(c); cfg_addr = 4'(a); cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic program_test1();
    int w0 [9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
    int w1 [9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
    for (int i = 0; i < 9; i++) begin
      write_w(0, i, DATA_W'(w0[i]));
      write_w(1, i, DATA_W'(w1[i]));
    end
  endtask

  task automatic start_win(input logic m, input int l);
    mode = m; len = 5'(l); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      in_valid = 1'b1;
      in_data  = samp[i];
      while (!in_ready && guard < 20) begin
        tick();
        guard++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
      if (gaps && i < n - 1) repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  // Called one cycle after the last handshake (DRAIN).
  task automatic finish_win(input string tag, input logic signed [ACC_W-1:0] e0,
                            input logic signed [ACC_W-1:0] e1, input int hold);
    logic [CH*ACC_W-1:0] snap;
    check({tag, "_drain_valid"}, 128'(out_valid), 0);
    check({tag, "_drain_ready"}, 128'(in_ready), 0);
    tick();
    check({tag, "_out_valid"}, 128'(out_valid), 1);
    snap = out_data;
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, "_hold_valid"}, 128'(out_valid), 1);
      check({tag, "_hold_data"}, 128'(out_data == snap), 1);
    end
    check({tag, "_ch0"}, res(0), e0);
    check({tag, "_ch1"}, res(1), e1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, 128'(busy), 0);
  endtask

  task automatic samples_1_to_9();
    for (int i = 0; i < 9; i++) samp[i] = DATA_W'(i + 1);
  endtask

  initial begin
    logic signed [DATA_W-1:0] mn;
    logic signed [ACC_W-1:0] big;
    mn  = -(DATA_W'(1) <<< 22);
    big = ACC_W'(9) <<< 44;

    repeat (3) tick();
    check("rst_out_valid", 128'(out_valid), 0);
    check("rst_in_ready", 128'(in_ready), 0);
    check("rst_busy", 128'(busy), 0);
    check("rst_err", 128'(err), 0);
    check("rst_out_data", 128'(out_data == '0), 1);
    rst_n = 1'b1;
    tick();

    // Conv with defaults, gap-free
    program_test1();
    samples_1_to_9();
    start_win(1'b0, 0);
    check("conv_in_ready", 128'(in_ready), 1);
    feed(9, 1'b0);
    finish_win("conv", 34, 25, 0);

    // Dense, len 4
    write_w(0, 0, -3); write_w(0, 1, 2); write_w(0, 2, 0); write_w(0, 3, 5);
    samp[0] = 7; samp[1] = -1; samp[2] = 9; samp[3] = 2;
    start_win(1'b1, 4);
    feed(4, 1'b0);
    finish_win("dense", -13, 16, 0);

    // Extremes
    for (int i = 0; i < 9; i++) begin
      write_w(0, i, mn);
      write_w(1, i, mn);
      samp[i] = mn;
    end
    start_win(1'b0, 0);
    feed(9, 1'b0);
    finish_win("extreme", big, big, 0);

    // Back-pressure: input gaps and output held 10 cycles
    program_test1();
    samples_1_to_9();
    start_win(1'b0, 0);
    feed(9, 1'b1);
    finish_win("bp", 34, 25, 10);

    // Errors
    start_win(1'b1, 0);
    check("len0_err", 128'(err), 1);
    check("len0_busy", 128'(busy), 0);
    tick();
    check("len0_err_pulse", 128'(err), 0);
    start_win(1'b1, 17);
    check("len17_err", 128'(err), 1);
    check("len17_busy", 128'(busy), 0);
    tick();
    check("len17_err_pulse", 128'(err), 0);
    start_win(1'b0, 0);
    write_w(0, 0, 100);
    check("we_busy_err", 128'(err), 1);
    check("we_busy_state", 128'(in_ready), 1);
    tick();
    check("we_busy_err_pulse", 128'(err), 0);
    feed(9, 1'b0);
    finish_win("we_drop", 34, 25, 0);

    // Reset mid-window
    start_win(1'b0, 0);
    feed(5, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_valid), 0);
    check("mid_rst_ready", 128'(in_ready), 0);
    check("mid_rst_busy", 128'(busy), 0);
    check("mid_rst_err", 128'(err), 0);
    check("mid_rst_data", 128'(out_data == '0), 1);
    tick();
    rst_n = 1'b1;
    tick();
    start_win(1'b0, 0);
    feed(9, 1'b0);
    finish_win("zero_w", 0, 0, 0);
    program_test1();
    start_win(1'b0, 0);
    feed(9, 1'b0);
    finish_win("reprog", 34, 25, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
